hazard_detect_unit: RTL and testbench

Decode-stage hazard detection and stall sequencer for the 5-stage pipelined MIPS core. It compares ID-stage source registers against destinations in ID/EX and EX/MEM and detects load-use and branch-operand hazards (branches resolve in ID). On a hazard it freezes the PC and the IF/ID register and drives the select of the downstream control bubble mux: 1 passes the decoded 9-bit control word into ID/EX, 0 inserts a bubble. It also flushes IF/ID on a taken branch and keeps a saturating stall-cycle counter.

---
 rtl/hazard_detect_unit_pkg.sv | 21 ++
 rtl/hazard_detect_unit_reg_match.sv | 16 +
 rtl/hazard_detect_unit.sv | 78 +++++++
 tb/tb_hazard_detect_unit.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/hazard_detect_unit_pkg.sv
// Shared definitions for the decode-stage hazard detector: FSM encoding,
// default widths and the hardwired-zero register specifier.
package hazard_detect_unit_pkg;

   localparam int REG_W_DEF = 5;
   localparam int CNT_W_DEF = 16;
   localparam int REG_ZERO  = 0;

   typedef enum logic {
      RUN  = 1'b0,
      HOLD = 1'b1
   } hdu_state_e;

   typedef struct packed {
      logic pc_write;
      logic ifid_write;
      logic ifid_flush;
      logic ctrl_sel;
   } hdu_ctl_t;

endpackage

// File: rtl/hazard_detect_unit_reg_match.sv
// Combinational Match(): true when a nonzero destination feeds an ID source.
module reg_match
   import hazard_detect_unit_pkg::*;
#(
   parameter int REG_W = REG_W_DEF
) (
   input  logic [REG_W-1:0] r,
   input  logic [REG_W-1:0] rs,
   input  logic [REG_W-1:0] rt,
   input  logic             uses_rt,
   output logic             match
);

   assign match = (r != REG_W'(REG_ZERO)) && ((r == rs) || (uses_rt && (r == rt)));

endmodule

// File: rtl/hazard_detect_unit.sv
// Decode-stage hazard detection, stall sequencing and branch flush for the
// 5-stage MIPS pipeline; also counts stall cycles with saturation.
module hazard_detect_unit
   import hazard_detect_unit_pkg::*;
#(
   parameter int REG_W = REG_W_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_uses_rt,
   input  logic             id_branch,
   input  logic             branch_taken,
   input  logic             idex_memread,
   input  logic             idex_regwrite,
   input  logic [REG_W-1:0] idex_rd,
   input  logic             exmem_memread,
   input  logic [REG_W-1:0] exmem_rd,
   output logic             pc_write,
   output logic             ifid_write,
   output logic             ifid_flush,
   output logic             ctrl_sel,
   output logic [CNT_W-1:0] stall_count
);

   hdu_state_e state;
   hdu_ctl_t   ctl;
   logic       m_ex, m_mem;
   logic       lu, ba, bl2, bl1, hazard, stall;

   reg_match #(.REG_W(REG_W)) u_match_ex (
      .r(idex_rd), .rs(id_rs), .rt(id_rt), .uses_rt(id_uses_rt), .match(m_ex)
   );

   reg_match #(.REG_W(REG_W)) u_match_mem (
      .r(exmem_rd), .rs(id_rs), .rt(id_rt), .uses_rt(id_uses_rt), .match(m_mem)
   );

   assign lu     = idex_memread && m_ex;
   assign ba     = id_branch && idex_regwrite && !idex_memread && m_ex;
   assign bl2    = id_branch && idex_memread && m_ex;
   assign bl1    = id_branch && exmem_memread && m_mem;
   assign hazard = lu || ba || bl1 || bl2;
   // HOLD is the second cycle of a branch-after-load stall; inputs are ignored there
   assign stall  = (state == HOLD) || hazard;

   always_comb begin
      ctl = '0;
      if (!rst) begin
         ctl.pc_write   = !stall;
         ctl.ifid_write = !stall;
         ctl.ctrl_sel   = !stall;
         ctl.ifid_flush = !stall && id_branch && branch_taken;
      end
   end

   assign pc_write   = ctl.pc_write;
   assign ifid_write = ctl.ifid_write;
   assign ifid_flush = ctl.ifid_flush;
   assign ctrl_sel   = ctl.ctrl_sel;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= RUN;
         stall_count <= '0;
      end else begin
         case (state)
            RUN:     state <= bl2 ? HOLD : RUN;
            default: state <= RUN;
         endcase
         if (stall && (stall_count != '1))
            stall_count <= stall_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_hazard_detect_unit.sv
// Self-checking bench: directed scenarios plus randomized stimulus against a
// cycle-level model of the stall rules (pending-stall count, saturating total).
module tb_hazard_detect_unit;

   logic        clk, rst;
   logic [4:0]  id_rs, id_rt, idex_rd, exmem_rd;
   logic        id_uses_rt, id_branch, branch_taken;
   logic        idex_memread, idex_regwrite, exmem_memread;
   logic        pc_write, ifid_write, ifid_flush, ctrl_sel;
   logic [15:0] stall_count;
   logic        s_pc_write, s_ifid_write, s_ifid_flush, s_ctrl_sel;
   logic [2:0]  s_stall_count;

   int total = 0;
   int bad   = 0;

   // reference model state
   int     pend_stalls = 0;
   longint stalls      = 0;

   hazard_detect_unit dut (
      .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
      .id_branch(id_branch), .branch_taken(branch_taken), .idex_memread(idex_memread),
      .idex_regwrite(idex_regwrite), .idex_rd(idex_rd), .exmem_memread(exmem_memread),
      .exmem_rd(exmem_rd), .pc_write(pc_write), .ifid_write(ifid_write),
      .ifid_flush(ifid_flush), .ctrl_sel(ctrl_sel), .stall_count(stall_count)
   );

   // narrow counter instance exercises saturation quickly
   hazard_detect_unit #(.REG_W(5), .CNT_W(3)) dut_s (
      .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
      .id_branch(id_branch), .branch_taken(branch_taken), .idex_memread(idex_memread),
      .idex_regwrite(idex_regwrite), .idex_rd(idex_rd), .exmem_memread(exmem_memread),
      .exmem_rd(exmem_rd), .pc_write(s_pc_write), .ifid_write(s_ifid_write),
      .ifid_flush(s_ifid_flush), .ctrl_sel(s_ctrl_sel), .stall_count(s_stall_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit uses(input logic [4:0] r);
      return (r != 0) && (r == id_rs || (id_uses_rt && r == id_rt));
   endfunction

   function automatic longint sat(input longint v, input int w);
      longint mx = (64'd1 << w) - 1;
      return (v > mx) ? mx : v;
   endfunction

   task automatic check_counts(input string tag);
      chk({tag, ".cnt"},   32'(stall_count),   32'(sat(stalls, 16)));
      chk({tag, ".scnt"},  32'(s_stall_count), 32'(sat(stalls, 3)));
   endtask

   task automatic zero_inputs();
      id_rs = 0; id_rt = 0; id_uses_rt = 0; id_branch = 0; branch_taken = 0;
      idex_memread = 0; idex_regwrite = 0; idex_rd = 0; exmem_memread = 0; exmem_rd = 0;
   endtask

   task automatic do_reset(input string tag);
      zero_inputs();
      rst = 1'b1;
      #1;
      chk({tag, ".pcw"},  32'(pc_write),   0);
      chk({tag, ".ifw"},  32'(ifid_write), 0);
      chk({tag, ".csel"}, 32'(ctrl_sel),   0);
      chk({tag, ".fl"},   32'(ifid_flush), 0);
      stalls = 0;
      pend_stalls = 0;
      check_counts(tag);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   // called just after a rising edge; drives one cycle and checks it
   task automatic step(input string tag,
                       input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                       input logic br, input logic tk,
                       input logic emr, input logic erw, input logic [4:0] erd,
                       input logic mmr, input logic [4:0] mrd);
      bit lu, ba, bl2, bl1, exp_stall;
      id_rs = rs; id_rt = rt; id_uses_rt = urt; id_branch = br; branch_taken = tk;
      idex_memread = emr; idex_regwrite = erw; idex_rd = erd;
      exmem_memread = mmr; exmem_rd = mrd;
      #3;
      lu  = emr && uses(erd);
      ba  = br && erw && !emr && uses(erd);
      bl2 = br && emr && uses(erd);
      bl1 = br && mmr && uses(mrd);
      exp_stall = (pend_stalls > 0) || lu || ba || bl2 || bl1;
      chk({tag, ".pcw"},  32'(pc_write),   32'(!exp_stall));
      chk({tag, ".ifw"},  32'(ifid_write), 32'(!exp_stall));
      chk({tag, ".csel"}, 32'(ctrl_sel),   32'(!exp_stall));
      chk({tag, ".fl"},   32'(ifid_flush), 32'(!exp_stall && br && tk));
      chk({tag, ".spcw"}, 32'(s_pc_write), 32'(!exp_stall));
      check_counts(tag);
      @(posedge clk);
      if (exp_stall) stalls++;
      if (pend_stalls > 0) pend_stalls--;
      else if (bl2) pend_stalls = 1;
      #1;
   endtask

   initial begin
      zero_inputs();
      rst = 1'b1;
      #2;
      do_reset("rst0");

      // load-use on rs: one stall then free
      step("lu1",  5'd2, 5'd7, 1, 0, 0, 1, 1, 5'd2, 0, 5'd0);
      step("lu2",  5'd2, 5'd7, 1, 0, 0, 0, 0, 5'd9, 0, 5'd0);
      // rt match without uses_rt, and register 0
      step("nort", 5'd5, 5'd2, 0, 0, 0, 1, 1, 5'd2, 0, 5'd0);
      step("r0",   5'd0, 5'd0, 1, 0, 0, 1, 1, 5'd0, 1, 5'd0);
      // branch after ALU op, then taken flush
      step("ba1",  5'd3, 5'd8, 1, 1, 1, 0, 1, 5'd3, 0, 5'd0);
      step("ba2",  5'd3, 5'd8, 1, 1, 1, 0, 0, 5'd6, 0, 5'd0);
      // branch after load: RUN stall then HOLD stall, flush suppressed
      step("bl2a", 5'd4, 5'd8, 1, 1, 1, 1, 1, 5'd4, 0, 5'd0);
      step("bl2b", 5'd4, 5'd8, 1, 1, 1, 0, 0, 5'd0, 1, 5'd4);
      step("bl2c", 5'd4, 5'd8, 1, 1, 1, 0, 0, 5'd0, 0, 5'd0);
      // branch after load in MEM only
      step("bl1",  5'd9, 5'd6, 1, 1, 0, 0, 0, 5'd0, 1, 5'd6);
      // reset in the middle of HOLD
      step("hold", 5'd4, 5'd8, 1, 1, 0, 1, 1, 5'd4, 0, 5'd0);
      do_reset("rsth");
      step("post", 5'd1, 5'd2, 1, 0, 0, 0, 0, 5'd0, 0, 5'd0);
      // saturation of the narrow counter: 9 straight load-use stalls
      for (int i = 0; i < 9; i++)
         step("sat", 5'd2, 5'd0, 0, 0, 0, 1, 1, 5'd2, 0, 5'd0);

      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 49) == 0) do_reset("rrst");
         step("rnd",
              5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
              1'($urandom), 1'($urandom),
              1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)),
              1'($urandom), 5'($urandom_range(0, 3)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
